instr_prefetch: RTL

INSTR_PREFETCH -- requirements
Module: instr_prefetch

---
 rtl/instr_prefetch_pkg.sv | 20 ++
 rtl/instr_prefetch_queue.sv | 79 +++++++
 rtl/instr_prefetch.sv | 121 ++++++++++++
 3 files changed

// File: rtl/instr_prefetch_pkg.sv
// Shared processor definitions: default fetch constants used by the fetch, decode and
// control blocks, plus small sizing helpers.
package instr_prefetch_pkg;

   localparam int unsigned DEF_INSTR_W  = 16;
   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_DEPTH    = 4;
   localparam int unsigned DEF_PC_INC   = 2;
   localparam int unsigned DEF_RESET_PC = 0;

   // Counters must hold every value from 0 to n inclusive.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic int unsigned ptr_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/instr_prefetch_queue.sv
// pf_queue: synchronous FIFO of {instruction, pc} entries with push, pop, flush
// and occupancy count; the head is read straight out of the storage registers.
module pf_queue
   import instr_prefetch_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = cnt_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CW-1:0]    count_o
);
   localparam int unsigned PW = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push_s, do_pop_s;

   // DEPTH need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PW'(1);
      end
   endfunction

   // Pointer and occupancy next state; flush discards everything.
   always_comb begin
      do_pop_s  = pop_i && (cnt_q != '0);
      do_push_s = push_i && ((cnt_q != CW'(DEPTH)) || do_pop_s);
      rd_d      = rd_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      if (flush_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         rd_d = do_pop_s ? ptr_inc(rd_q) : rd_q;
         wr_d = do_push_s ? ptr_inc(wr_q) : wr_q;
         case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (!flush_i && do_push_s) begin
            mem_q[wr_q] <= din_i;
         end
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetcher: credit-limited fetch issue, in-order response capture,
// redirect flush with stale-response dropping, sticky protocol error.
module instr_prefetch
   import instr_prefetch_pkg::*;
#(
   parameter int unsigned INSTR_W  = DEF_INSTR_W,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DEPTH    = DEF_DEPTH,
   parameter int unsigned PC_INC   = DEF_PC_INC,
   parameter int unsigned RESET_PC = DEF_RESET_PC
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               halt,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_gnt,
   input  logic               mem_rvalid,
   input  logic [INSTR_W-1:0] mem_rdata,
   output logic               out_valid,
   output logic [INSTR_W-1:0] out_instr,
   output logic [ADDR_W-1:0]  out_pc,
   output logic [ADDR_W-1:0]  out_next_pc,
   input  logic               out_ready,
   output logic               err
);
   localparam int unsigned       CW  = cnt_width(DEPTH);
   localparam int unsigned       CW1 = CW + 1;
   localparam int unsigned       QW  = INSTR_W + ADDR_W;
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);
   localparam logic [ADDR_W-1:0] RPC = ADDR_W'(RESET_PC);

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]     inflight_q, inflight_d, drop_q, drop_d;
   logic              err_q, err_d;
   logic [CW-1:0]     count_s;
   logic [QW-1:0]     head_s;
   logic              rv_live_s, credit_s, grant_s, push_s, pop_s;

   // Issue, capture and redirect decisions; redirect overrides all other events.
   always_comb begin
      rv_live_s  = mem_rvalid && (inflight_q != '0);
      credit_s   = ({1'b0, count_s} + {1'b0, inflight_q}) < CW1'(DEPTH);
      mem_req    = !rst && !redirect && !halt && credit_s;
      grant_s    = mem_req && mem_gnt;
      push_s     = rv_live_s && (drop_q == '0) && !redirect;
      pop_s      = out_valid && out_ready && !redirect;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rsp_pc_d   = redirect_pc;
         inflight_d = inflight_q - CW'(rv_live_s);
         // Stale requests are already part of inflight, so every survivor is dropped.
         drop_d     = inflight_q - CW'(rv_live_s);
      end else begin
         fetch_pc_d = grant_s ? (fetch_pc_q + INC) : fetch_pc_q;
         inflight_d = inflight_q + CW'(grant_s) - CW'(rv_live_s);
         if (rv_live_s && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end else if (push_s) begin
            rsp_pc_d = rsp_pc_q + INC;
         end else begin
            drop_d = drop_q;
         end
      end
      err_d = err_q;
      if (mem_rvalid && (inflight_q == '0)) begin
         err_d = 1'b1;
      end else if (push_s && (count_s == CW'(DEPTH))) begin
         err_d = 1'b1;
      end else if (redirect && ((redirect_pc % INC) != '0)) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Fetch/response PCs, credit counters and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RPC;
         rsp_pc_q   <= RPC;
         inflight_q <= '0;
         drop_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   pf_queue #(
      .WIDTH (QW),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect),
      .push_i  (push_s),
      .din_i   ({mem_rdata, rsp_pc_q}),
      .pop_i   (pop_s),
      .dout_o  (head_s),
      .count_o (count_s)
   );

   assign mem_addr    = fetch_pc_q;
   assign out_valid   = (count_s != '0);
   assign out_instr   = head_s[QW-1:ADDR_W];
   assign out_pc      = head_s[ADDR_W-1:0];
   assign out_next_pc = out_pc + INC;
   assign err         = err_q;

endmodule
